field_lock_clear: RTL and testbench
===================================

Name: field_lock_clear

Overview:
Playfield store and line-clear engine, directly downstream of the falling-block controller. On a lock pulse it writes the four square coordinates of the landed piece into a ROWS x COLS occupancy map, then scans for full rows and collapses each one by shifting the rows above it down. It reports the line count and score increment per lock, raises a sticky game-over flag, and serves one row at a time to the renderer and collision logic.

Parameters:
COLS, 10, playfield width in cells (col index 0..COLS-1)
ROWS, 20, playfield height in rows (row 0 = top)
TOP_ROWS, 1, rows 0..TOP_ROWS-1 form the spawn zone; a lock there triggers game over

Ports:
pclk  in  1  system clock
rst  in  1  asynchronous active-low reset
lock_en  in  1  one-cycle pulse: latch the sq_* coordinates and write them into the field
sq_1_col, sq_2_col, sq_3_col, sq_4_col  in  4 each  column of each square of the locking piece
sq_1_row, sq_2_row, sq_3_row, sq_4_row  in  5 each  row of each square of the locking piece
clr_board  in  1  pulse: empty the whole field and clear game_over (honoured only in IDLE)
rd_row  in  5  row address for the read port
rd_data  out  COLS  occupancy of rd_row, registered, 1-cycle latency; 0 when rd_row >= ROWS
busy  out  1  high from the cycle after an accepted lock_en until DONE completes
clear_done  out  1  one-cycle pulse when the scan finishes
lines  out  3  full rows removed by the last lock (0..4), valid with clear_done and held until the next one
score_add  out  11  0/40/100/300/1200 for lines 0/1/2/3/4, same timing as lines
game_over  out  1  sticky; set when any written square has row < TOP_ROWS

Behaviour:
- Reset (rst=0, async): field all zero, state IDLE, rd_data=0, busy=0, clear_done=0, lines=0, score_add=0, game_over=0. Reset applied mid-scan aborts the operation with no partial result.
- IDLE: on lock_en=1, register the 8 coordinates, go to WRITE, busy=1 next cycle. If lock_en and clr_board are high together, lock_en takes priority and clr_board is dropped.
- IDLE, clr_board=1 without lock_en: all rows cleared and game_over cleared in one cycle; state stays IDLE.
- WRITE (1 cycle): OR each in-range square into the field. A square with col >= COLS or row >= ROWS is ignored. Duplicate coordinates are harmless. game_over is set if any in-range square has row < TOP_ROWS. Next state SCAN with r = ROWS-1 and the line counter at 0.
- SCAN (1 cycle per row): if row r is all ones, increment the line counter and go to SHIFT with s = r. Otherwise decrement r; after row 0 has been checked, go to DONE.
- SHIFT (1 cycle per row): row[s] <= row[s-1], then s decrements. At s = 0, row[0] <= 0 and the state returns to SCAN with the same r, which now holds the row above.
- DONE (1 cycle): clear_done=1, lines and score_add updated, busy=0 in the following cycle, return to IDLE.
- Latency: an empty scan takes 1 + ROWS + 1 cycles. Each cleared row adds r+1 SHIFT cycles plus one rescan of r.
- lock_en while busy=1 is ignored. The upstream controller must not re-lock before clear_done.
- The line counter saturates at 4. More than 4 full rows cannot occur from a single piece.
- The read port stays active in every state. During SHIFT, rd_data returns the current partially shifted content; the renderer tolerates one transient frame.
- Widths: COLS <= 16, ROWS <= 32. The score lookup is a constant case on lines.

Decomposition:
- Shared package: COLS, ROWS, TOP_ROWS defaults; FSM state encodings IDLE/WRITE/SCAN/SHIFT/DONE; the score constants 40/100/300/1200.
- One sub-module: field_row_mem, the ROWS x COLS register array with set-bit, row-copy, row-clear, clear-all and registered read port. It is instantiated once, and the FSM stays in field_lock_clear.

Test Plan:
- Reset and read: hold rst=0, then release → rd_data=0 for rd_row 0..19, busy=0, game_over=0; rd_row=25 → rd_data=0.
- Single lock, no line: lock squares (4,19),(5,19),(6,19),(5,18) → busy for 22 cycles, clear_done with lines=0, score_add=0; row 19 reads 0x070, row 18 reads 0x020.
- Single clear: pre-fill row 19 columns 0..5, then lock an I piece at (6..9,19) → lines=1, score_add=40, row 19 reads 0, prior row 18 content moves to row 19.
- Tetris: rows 16..19 filled at columns 0..8, lock a vertical I at col 9 rows 16..19 → lines=4, score_add=1200, whole field empty.
- Game over and clear: lock a square at row 0 → game_over=1 after WRITE and held through later locks; clr_board in IDLE → game_over=0, field empty next cycle.
- Robustness: lock_en pulsed during busy → ignored, field unchanged; square with col=12 → not written, no error; rst deasserted then asserted mid-SHIFT → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/field_lock_clear_pkg.sv
// Shared sizes, FSM encoding and score table for the playfield store and line-clear engine.
package field_lock_clear_pkg;

  localparam int unsigned COLS     = 10;
  localparam int unsigned ROWS     = 20;
  localparam int unsigned TOP_ROWS = 1;

  localparam int unsigned ColW   = 4;
  localparam int unsigned RowW   = 5;
  localparam int unsigned LinesW = 3;
  localparam int unsigned ScoreW = 11;

  localparam logic [ScoreW-1:0] Score1 = 11'd40;
  localparam logic [ScoreW-1:0] Score2 = 11'd100;
  localparam logic [ScoreW-1:0] Score3 = 11'd300;
  localparam logic [ScoreW-1:0] Score4 = 11'd1200;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StScan,
    StShift,
    StDone
  } state_e;

  function automatic logic [ScoreW-1:0] score_of(input logic [LinesW-1:0] n);
    case (n)
      3'd1:    return Score1;
      3'd2:    return Score2;
      3'd3:    return Score3;
      3'd4:    return Score4;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/field_lock_clear_if.sv
// Lock, board-clear, read-port and status signals between the piece controller/renderer and
// the playfield engine.
interface field_lock_clear_if #(
  parameter int unsigned Cols = field_lock_clear_pkg::COLS
);
  import field_lock_clear_pkg::*;

  logic              lock_en;
  logic [ColW-1:0]   sq_1_col;
  logic [ColW-1:0]   sq_2_col;
  logic [ColW-1:0]   sq_3_col;
  logic [ColW-1:0]   sq_4_col;
  logic [RowW-1:0]   sq_1_row;
  logic [RowW-1:0]   sq_2_row;
  logic [RowW-1:0]   sq_3_row;
  logic [RowW-1:0]   sq_4_row;
  logic              clr_board;
  logic [RowW-1:0]   rd_row;
  logic [Cols-1:0]   rd_data;
  logic              busy;
  logic              clear_done;
  logic [LinesW-1:0] lines;
  logic [ScoreW-1:0] score_add;
  logic              game_over;

  modport master (
    output lock_en, sq_1_col, sq_2_col, sq_3_col, sq_4_col,
           sq_1_row, sq_2_row, sq_3_row, sq_4_row, clr_board, rd_row,
    input  rd_data, busy, clear_done, lines, score_add, game_over
  );

  modport slave (
    input  lock_en, sq_1_col, sq_2_col, sq_3_col, sq_4_col,
           sq_1_row, sq_2_row, sq_3_row, sq_4_row, clr_board, rd_row,
    output rd_data, busy, clear_done, lines, score_add, game_over
  );

endinterface

// File: rtl/field_row_mem.sv
// Rows x Cols occupancy register array: four-bit set, row shift-down, clear-all,
// combinational scan port and registered read port.
module field_row_mem
  import field_lock_clear_pkg::*;
#(
  parameter int unsigned Cols = COLS,
  parameter int unsigned Rows = ROWS
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            clear_all,
  input  logic [3:0]      set_vld,
  input  logic [ColW-1:0] set_col [4],
  input  logic [RowW-1:0] set_row [4],
  input  logic            shift_en,
  input  logic [RowW-1:0] shift_row,
  input  logic [RowW-1:0] scan_row,
  output logic [Cols-1:0] scan_data,
  input  logic [RowW-1:0] rd_row,
  output logic [Cols-1:0] rd_data
);

  logic [Cols-1:0] rows_q [Rows];
  logic [Cols-1:0] rows_d [Rows];
  logic [Cols-1:0] rd_data_d, rd_data_q;

  always_comb begin
    for (int i = 0; i < Rows; i++) rows_d[i] = rows_q[i];
    if (clear_all) begin
      for (int i = 0; i < Rows; i++) rows_d[i] = '0;
    end else if (shift_en) begin
      // Row 0 has nothing above it, so it is refilled with empty cells.
      if (shift_row == '0) rows_d[0] = '0;
      for (int i = 1; i < Rows; i++) begin
        if (RowW'(i) == shift_row) rows_d[i] = rows_q[i-1];
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < Rows; i++) begin
          for (int j = 0; j < Cols; j++) begin
            if (set_vld[k] && RowW'(i) == set_row[k] && ColW'(j) == set_col[k]) begin
              rows_d[i][j] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Out-of-range addresses match no row and therefore read as zero.
  always_comb begin
    scan_data = '0;
    rd_data_d = '0;
    for (int i = 0; i < Rows; i++) begin
      if (RowW'(i) == scan_row) scan_data = rows_q[i];
      if (RowW'(i) == rd_row)   rd_data_d = rows_q[i];
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Rows; i++) rows_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i < Rows; i++) rows_q[i] <= rows_d[i];
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/field_lock_clear.sv
// Playfield store and line-clear engine: writes a locked piece, then scans bottom-up and
// collapses full rows, reporting line count, score increment and a sticky game-over flag.
module field_lock_clear
  import field_lock_clear_pkg::*;
#(
  parameter int unsigned Cols    = COLS,
  parameter int unsigned Rows    = ROWS,
  parameter int unsigned TopRows = TOP_ROWS
) (
  input logic               pclk,
  input logic               rst,
  field_lock_clear_if.slave bus
);

  state_e            state_q, state_d;
  logic [RowW-1:0]   r_q, r_d;
  logic [RowW-1:0]   s_q, s_d;
  logic [LinesW-1:0] cnt_q, cnt_d;
  logic [LinesW-1:0] lines_q, lines_d;
  logic [ScoreW-1:0] score_q, score_d;
  logic              game_over_q, game_over_d;
  logic [ColW-1:0]   sq_col_q [4];
  logic [ColW-1:0]   sq_col_d [4];
  logic [RowW-1:0]   sq_row_q [4];
  logic [RowW-1:0]   sq_row_d [4];

  logic [3:0]        set_vld;
  logic              top_hit;
  logic              clear_all;
  logic              shift_en;
  logic [Cols-1:0]   scan_data;

  always_comb begin
    set_vld = '0;
    top_hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_vld[k] = (state_q == StWrite) && (32'(sq_col_q[k]) < Cols) &&
                   (32'(sq_row_q[k]) < Rows);
      if (set_vld[k] && 32'(sq_row_q[k]) < TopRows) top_hit = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    s_d         = s_q;
    cnt_d       = cnt_q;
    lines_d     = lines_q;
    score_d     = score_q;
    game_over_d = game_over_q;
    clear_all   = 1'b0;
    shift_en    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sq_col_d[k] = sq_col_q[k];
      sq_row_d[k] = sq_row_q[k];
    end

    case (state_q)
      StIdle: begin
        // A simultaneous clr_board is dropped in favour of the lock.
        if (bus.lock_en) begin
          sq_col_d[0] = bus.sq_1_col;
          sq_col_d[1] = bus.sq_2_col;
          sq_col_d[2] = bus.sq_3_col;
          sq_col_d[3] = bus.sq_4_col;
          sq_row_d[0] = bus.sq_1_row;
          sq_row_d[1] = bus.sq_2_row;
          sq_row_d[2] = bus.sq_3_row;
          sq_row_d[3] = bus.sq_4_row;
          state_d     = StWrite;
        end else if (bus.clr_board) begin
          clear_all   = 1'b1;
          game_over_d = 1'b0;
        end
      end
      StWrite: begin
        if (top_hit) game_over_d = 1'b1;
        r_d     = RowW'(Rows - 1);
        cnt_d   = '0;
        state_d = StScan;
      end
      StScan: begin
        if (&scan_data) begin
          if (cnt_q != 3'd4) cnt_d = cnt_q + 3'd1;
          s_d     = r_q;
          state_d = StShift;
        end else if (r_q == '0) begin
          lines_d = cnt_q;
          score_d = score_of(cnt_q);
          state_d = StDone;
        end else begin
          r_d = r_q - RowW'(1);
        end
      end
      StShift: begin
        // r is left untouched so the row that dropped into it gets rescanned.
        shift_en = 1'b1;
        if (s_q == '0) state_d = StScan;
        else           s_d     = s_q - RowW'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      r_q         <= '0;
      s_q         <= '0;
      cnt_q       <= '0;
      lines_q     <= '0;
      score_q     <= '0;
      game_over_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        sq_col_q[k] <= '0;
        sq_row_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      lines_q     <= lines_d;
      score_q     <= score_d;
      game_over_q <= game_over_d;
      for (int k = 0; k < 4; k++) begin
        sq_col_q[k] <= sq_col_d[k];
        sq_row_q[k] <= sq_row_d[k];
      end
    end
  end

  field_row_mem #(
    .Cols (Cols),
    .Rows (Rows)
  ) u_mem (
    .pclk      (pclk),
    .rst       (rst),
    .clear_all (clear_all),
    .set_vld   (set_vld),
    .set_col   (sq_col_q),
    .set_row   (sq_row_q),
    .shift_en  (shift_en),
    .shift_row (s_q),
    .scan_row  (r_q),
    .scan_data (scan_data),
    .rd_row    (bus.rd_row),
    .rd_data   (bus.rd_data)
  );

  assign bus.busy       = (state_q != StIdle);
  assign bus.clear_done = (state_q == StDone);
  assign bus.lines      = lines_q;
  assign bus.score_add  = score_q;
  assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_field_lock_clear.sv
// Directed bench for field_lock_clear: locks, line clears, tetris, game over, reset abort.
module tb_field_lock_clear;
  import field_lock_clear_pkg::*;

  logic pclk = 1'b0;
  logic rst  = 1'b0;

  field_lock_clear_if bus ();

  field_lock_clear dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 pclk = ~pclk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          last_cyc;
  int          last_done;
  logic        last_ok;
  logic [2:0]  last_lines;
  logic [10:0] last_score;
  logic [15:0] rd_val;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_lock(input int c1, input int r1, input int c2, input int r2,
                            input int c3, input int r3, input int c4, input int r4,
                            input bit clr);
    bus.sq_1_col  = 4'(c1);
    bus.sq_1_row  = 5'(r1);
    bus.sq_2_col  = 4'(c2);
    bus.sq_2_row  = 5'(r2);
    bus.sq_3_col  = 4'(c3);
    bus.sq_3_row  = 5'(r3);
    bus.sq_4_col  = 4'(c4);
    bus.sq_4_row  = 5'(r4);
    bus.lock_en   = 1'b1;
    bus.clr_board = clr;
    @(negedge pclk);
    bus.lock_en   = 1'b0;
    bus.clr_board = 1'b0;
  endtask

  task automatic wait_done();
    last_cyc  = 0;
    last_done = 0;
    for (int i = 0; i < 3000; i++) begin
      if (bus.busy) last_cyc++;
      if (bus.clear_done) begin
        last_done++;
        last_lines = bus.lines;
        last_score = bus.score_add;
      end
      if (!bus.busy && last_cyc > 0) break;
      @(negedge pclk);
    end
    last_ok = !bus.busy && (last_done > 0);
    if (!last_ok) check_eq("lock_timeout", 32'd0, 32'd1);
  endtask

  task automatic lock_piece(input int c1, input int r1, input int c2, input int r2,
                            input int c3, input int r3, input int c4, input int r4);
    start_lock(c1, r1, c2, r2, c3, r3, c4, r4, 1'b0);
    wait_done();
  endtask

  task automatic read_row(input int r, output logic [15:0] val);
    bus.rd_row = 5'(r);
    @(negedge pclk);
    val = 16'(bus.rd_data);
  endtask

  task automatic field_or(output logic [15:0] acc);
    logic [15:0] v;
    acc = '0;
    for (int r = 0; r < 20; r++) begin
      read_row(r, v);
      acc = acc | v;
    end
  endtask

  task automatic clear_board();
    bus.clr_board = 1'b1;
    @(negedge pclk);
    bus.clr_board = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.lock_en   = 1'b0;
    bus.clr_board = 1'b0;
    bus.rd_row    = '0;
    bus.sq_1_col  = '0;
    bus.sq_2_col  = '0;
    bus.sq_3_col  = '0;
    bus.sq_4_col  = '0;
    bus.sq_1_row  = '0;
    bus.sq_2_row  = '0;
    bus.sq_3_row  = '0;
    bus.sq_4_row  = '0;

    // Reset state
    repeat (3) @(negedge pclk);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.clear_done), 32'd0);
    check_eq("rst_lines", 32'(bus.lines), 32'd0);
    check_eq("rst_score", 32'(bus.score_add), 32'd0);
    check_eq("rst_go", 32'(bus.game_over), 32'd0);
    rst = 1'b1;
    @(negedge pclk);
    field_or(rd_val);
    check_eq("rst_field", 32'(rd_val), 32'h0);
    read_row(25, rd_val);
    check_eq("rst_row25", 32'(rd_val), 32'h0);

    // Single lock, no line: WRITE + 20 SCAN + DONE
    lock_piece(4, 19, 5, 19, 6, 19, 5, 18);
    check_eq("t1_cycles", 32'(last_cyc), 32'd22);
    check_eq("t1_done_pulses", 32'(last_done), 32'd1);
    check_eq("t1_lines", 32'(last_lines), 32'd0);
    check_eq("t1_score", 32'(last_score), 32'd0);
    read_row(19, rd_val);
    check_eq("t1_row19", 32'(rd_val), 32'h070);
    read_row(18, rd_val);
    check_eq("t1_row18", 32'(rd_val), 32'h020);
    read_row(25, rd_val);
    check_eq("t1_row25", 32'(rd_val), 32'h0);

    // Single clear: row 18 (cols 0 and 9) drops into row 19
    clear_board();
    lock_piece(0, 19, 1, 19, 2, 19, 3, 19);
    lock_piece(4, 19, 5, 19, 0, 18, 9, 18);
    lock_piece(6, 19, 7, 19, 8, 19, 9, 19);
    check_eq("t2_lines", 32'(last_lines), 32'd1);
    check_eq("t2_score", 32'(last_score), 32'd40);
    check_eq("t2_cycles", 32'(last_cyc), 32'd43);
    read_row(19, rd_val);
    check_eq("t2_row19", 32'(rd_val), 32'h201);
    read_row(18, rd_val);
    check_eq("t2_row18", 32'(rd_val), 32'h0);
    check_eq("t2_go", 32'(bus.game_over), 32'd0);

    // Tetris
    clear_board();
    for (int r = 16; r <= 19; r++) begin
      lock_piece(0, r, 1, r, 2, r, 3, r);
      lock_piece(4, r, 5, r, 6, r, 7, r);
      lock_piece(8, r, 8, r, 8, r, 8, r);
    end
    check_eq("t3_fill_lines", 32'(last_lines), 32'd0);
    lock_piece(9, 16, 9, 17, 9, 18, 9, 19);
    check_eq("t3_lines", 32'(last_lines), 32'd4);
    check_eq("t3_score", 32'(last_score), 32'd1200);
    field_or(rd_val);
    check_eq("t3_field_empty", 32'(rd_val), 32'h0);

    // Game over, sticky, then cleared by clr_board
    clear_board();
    lock_piece(3, 0, 3, 0, 3, 0, 3, 0);
    check_eq("t4_go_set", 32'(bus.game_over), 32'd1);
    read_row(0, rd_val);
    check_eq("t4_row0", 32'(rd_val), 32'h008);
    lock_piece(0, 19, 0, 19, 0, 19, 0, 19);
    check_eq("t4_go_held", 32'(bus.game_over), 32'd1);
    clear_board();
    check_eq("t4_go_clr", 32'(bus.game_over), 32'd0);
    field_or(rd_val);
    check_eq("t4_field_empty", 32'(rd_val), 32'h0);

    // Robustness: lock during busy ignored, out-of-range squares ignored, lock beats clr
    start_lock(0, 19, 0, 19, 0, 19, 0, 19, 1'b0);
    start_lock(9, 10, 9, 10, 9, 10, 9, 10, 1'b0);
    wait_done();
    read_row(10, rd_val);
    check_eq("t5_busy_lock_row10", 32'(rd_val), 32'h0);
    read_row(19, rd_val);
    check_eq("t5_row19", 32'(rd_val), 32'h001);
    lock_piece(12, 5, 12, 5, 2, 31, 1, 5);
    read_row(5, rd_val);
    check_eq("t5_col12_row5", 32'(rd_val), 32'h002);
    check_eq("t5_go", 32'(bus.game_over), 32'd0);
    start_lock(0, 10, 0, 10, 0, 10, 0, 10, 1'b1);
    wait_done();
    read_row(19, rd_val);
    check_eq("t5_clr_dropped", 32'(rd_val), 32'h001);
    read_row(10, rd_val);
    check_eq("t5_lock_wins", 32'(rd_val), 32'h001);

    // Reset mid-SHIFT aborts everything
    clear_board();
    lock_piece(0, 19, 1, 19, 2, 19, 3, 19);
    lock_piece(4, 19, 5, 19, 6, 19, 7, 19);
    lock_piece(8, 19, 9, 19, 0, 0, 0, 0);
    check_eq("t6_pre_lines", 32'(last_lines), 32'd1);
    check_eq("t6_pre_go", 32'(bus.game_over), 32'd1);
    read_row(1, rd_val);
    check_eq("t6_row1", 32'(rd_val), 32'h001);
    lock_piece(0, 19, 1, 19, 2, 19, 3, 19);
    lock_piece(4, 19, 5, 19, 6, 19, 7, 19);
    start_lock(8, 19, 9, 19, 9, 19, 9, 19, 1'b0);
    repeat (3) @(negedge pclk);
    check_eq("t6_busy_mid", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("t6_busy", 32'(bus.busy), 32'd0);
    check_eq("t6_done", 32'(bus.clear_done), 32'd0);
    check_eq("t6_lines", 32'(bus.lines), 32'd0);
    check_eq("t6_score", 32'(bus.score_add), 32'd0);
    check_eq("t6_go", 32'(bus.game_over), 32'd0);
    check_eq("t6_rd_data", 32'(bus.rd_data), 32'h0);
    @(negedge pclk);
    rst = 1'b1;
    field_or(rd_val);
    check_eq("t6_field_empty", 32'(rd_val), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
